hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have the parameter MAX_INFLIGHT, default 3, giving the maximum number of issued, unretired writes per register (2-bit counter).
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have the port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have the port id_valid, input, 1 bit: the decode stage holds a valid instruction.
REQ-005 The block SHALL have the ports rs1_r_ena / rs2_r_ena, input, 1 bit each: the decoded instruction reads rs1 / rs2.
REQ-006 The block SHALL have the ports rs1_r_addr / rs2_r_addr, input, 5 bits each: source register indices.
REQ-007 The block SHALL have the port rd_w_ena, input, 1 bit: the decoded instruction writes rd.
REQ-008 The block SHALL have the port rd_w_addr, input, 5 bits: destination register index.
REQ-009 The block SHALL have the port serialize, input, 1 bit: the decoded instruction is CSR, fence or ecall/ebreak and must run alone.
REQ-010 The block SHALL have the port ex_redirect, input, 1 bit: the execute stage resolved a taken branch/jump this cycle.
REQ-011 The block SHALL have the ports wb_w_ena, input, 1 bit, and wb_w_addr, input, 5 bits: a register write retires this cycle.
REQ-012 The block SHALL have the port mem_busy, input, 1 bit: the memory stage is waiting on the bus.
REQ-013 The block SHALL have the port issue, output, 1 bit: the decode instruction advances to execute this cycle.
REQ-014 The block SHALL have the port if_stall, output, 1 bit: hold PC and the IF/ID register.
REQ-015 The block SHALL have the port id_flush, output, 1 bit: invalidate the IF/ID register.
REQ-016 The block SHALL have the port ex_bubble, output, 1 bit: insert a NOP into ID/EX.
REQ-017 The block SHALL have the port pipe_empty, output, 1 bit: no register write is pending.

Function
REQ-018 The block SHALL keep a scoreboard of 32 counters, each 2 bits; counter 0 SHALL stay 0.
REQ-019 The block SHALL treat a source as hazarded when its read-enable is 1, its address is nonzero, and its counter is nonzero.
REQ-020 The block SHALL have an FSM with the states RUN, DRAIN, SERIAL and FLUSH.
REQ-021 In RUN, issue SHALL be id_valid & ~hazard & ~mem_busy & ~ex_redirect & ~full & ~(serialize & ~pipe_empty), where full means the rd counter equals MAX_INFLIGHT.
REQ-022 On issue with rd_w_ena=1 and rd_w_addr≠0, the rd counter SHALL increment by 1.
REQ-023 On wb_w_ena=1 with wb_w_addr≠0, the counter for wb_w_addr SHALL decrement by 1; a decrement at 0 SHALL be ignored.
REQ-024 An increment and a decrement of the same register in the same cycle SHALL leave its counter unchanged.
REQ-025 pipe_empty SHALL be 1 when all counters are 0, computed combinationally from the current counters.
REQ-026 In RUN, an id_valid & serialize instruction with pipe_empty=0 SHALL move the FSM to DRAIN, with issue=0, if_stall=1 and ex_bubble=1.
REQ-027 In DRAIN, the FSM SHALL hold if_stall=1 and ex_bubble=1 until pipe_empty=1 and mem_busy=0, then issue that cycle and go to SERIAL.
REQ-028 In SERIAL, the FSM SHALL hold if_stall=1 and ex_bubble=1 for exactly 2 cycles (the instruction passes EX and MEM), then return to RUN.
REQ-029 When ex_redirect=1 in any state, the block SHALL set id_flush=1, issue=0 and ex_bubble=1, and enter FLUSH.
REQ-030 FLUSH SHALL last 1 cycle with issue=0, then the FSM SHALL go to RUN.
REQ-031 ex_redirect SHALL take priority over every stall condition.
REQ-032 The block SHALL NOT change scoreboard counters on flush, because squashed instructions were never issued.
REQ-033 A hazard, mem_busy or full condition in RUN SHALL give if_stall=1, ex_bubble=1 and issue=0, with the FSM staying in RUN.
REQ-034 The block SHALL latch no instruction data; outputs SHALL be combinational from the FSM state, the scoreboard and the inputs.

Reset
REQ-035 While rst=1, the block SHALL clear all counters, force the FSM to RUN, and drive issue=0, if_stall=0, id_flush=0, ex_bubble=0 and pipe_empty=1.
REQ-036 A rst assertion mid-DRAIN or mid-SERIAL SHALL abort immediately with no further issue.
REQ-037 After rst deasserts, the block SHALL allow issue in the first clock edge cycle.

Verification
REQ-038 The bench SHALL cover: issue add x5 (rd=5), next cycle the instruction reads rs1=5 -> issue=0 and if_stall=1 until wb_w_ena with wb_w_addr=5, then issue=1 the same cycle.
REQ-039 The bench SHALL cover: rd=0 issued repeatedly -> counter 0 stays 0 and pipe_empty stays 1.
REQ-040 The bench SHALL cover: 3 writes to x7 with no retire, then a 4th write to x7 -> the 4th stalls; after one wb to x7 it issues.
REQ-041 The bench SHALL cover: csrrw with x3 pending -> DRAIN, then after the x3 writeback issue=1, then SERIAL for 2 cycles, then RUN.
REQ-042 The bench SHALL cover: ex_redirect together with a hazard stall -> id_flush=1 and issue=0, then FLUSH for 1 cycle, and the counters are unchanged.
REQ-043 The bench SHALL cover: rst asserted during DRAIN -> all outputs at reset values asynchronously, and pipe_empty=1.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: scoreboard-based issue/stall/flush control for an in-order pipeline
module hazard_ctrl #(
  parameter int MAX_INFLIGHT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic       rs1_r_ena,
  input  logic [4:0] rs1_r_addr,
  input  logic       rs2_r_ena,
  input  logic [4:0] rs2_r_addr,
  input  logic       rd_w_ena,
  input  logic [4:0] rd_w_addr,
  input  logic       serialize,
  input  logic       ex_redirect,
  input  logic       wb_w_ena,
  input  logic [4:0] wb_w_addr,
  input  logic       mem_busy,
  output logic       issue,
  output logic       if_stall,
  output logic       id_flush,
  output logic       ex_bubble,
  output logic       pipe_empty
);
  typedef enum logic [1:0] {RUN, DRAIN, SERIAL, FLUSH} state_t;
  state_t state, state_nx;
  logic [1:0] cnt [32];
  logic ser_cnt;
  logic wb_ok, any_pending;
  logic [1:0] rs1_cnt, rs2_cnt, rd_cnt, rd_eff;
  logic rs1_dec, rs2_dec, rd_dec;
  logic hazard, full, run_issue, run_stall, drain_go, hold;
  logic [31:0] inc_vec, dec_vec;
  // Any nonzero counter means a register write is still pending
  always_comb begin
    any_pending = 1'b0;
    for (int i = 1; i < 32; i++) any_pending = any_pending | (|cnt[i]);
  end
  assign pipe_empty = ~any_pending;
  // Hazard/full evaluation, treating a same-cycle writeback as already retired
  always_comb begin
    wb_ok     = wb_w_ena & (|wb_w_addr);
    rs1_cnt   = cnt[rs1_r_addr];
    rs2_cnt   = cnt[rs2_r_addr];
    rd_cnt    = cnt[rd_w_addr];
    rs1_dec   = wb_ok && wb_w_addr == rs1_r_addr && rs1_cnt != 2'd0;
    rs2_dec   = wb_ok && wb_w_addr == rs2_r_addr && rs2_cnt != 2'd0;
    rd_dec    = wb_ok && wb_w_addr == rd_w_addr && rd_cnt != 2'd0;
    rd_eff    = rd_cnt - 2'(rd_dec);
    hazard    = (rs1_r_ena && (|rs1_r_addr) && rs1_cnt > 2'(rs1_dec)) ||
                (rs2_r_ena && (|rs2_r_addr) && rs2_cnt > 2'(rs2_dec));
    full      = rd_w_ena && (|rd_w_addr) && rd_eff == 2'(MAX_INFLIGHT);
    run_issue = id_valid & ~hazard & ~mem_busy & ~ex_redirect & ~full & ~(serialize & ~pipe_empty);
    run_stall = mem_busy | (id_valid & (hazard | full | (serialize & ~pipe_empty)));
    drain_go  = id_valid & pipe_empty & ~mem_busy;
  end
  // Pipeline control outputs; redirect wins over every stall, reset forces all low
  always_comb begin
    hold      = state == RUN ? run_stall : state == DRAIN ? ~drain_go : state == SERIAL;
    issue     = ~rst & ~ex_redirect & (state == RUN ? run_issue : (state == DRAIN) & drain_go);
    if_stall  = ~rst & ~ex_redirect & hold;
    ex_bubble = ~rst & (ex_redirect | hold | state == FLUSH);
    id_flush  = ~rst & ex_redirect;
  end
  // Next-state selection
  always_comb begin
    state_nx = ex_redirect ? FLUSH :
               state == RUN ? ((id_valid & serialize & ~pipe_empty) ? DRAIN :
                               (run_issue & serialize) ? SERIAL : RUN) :
               state == DRAIN ? (drain_go ? SERIAL : id_valid ? DRAIN : RUN) :
               state == SERIAL ? (ser_cnt ? RUN : SERIAL) : RUN;
  end
  // State register and two-cycle serial window counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      ser_cnt <= 1'b0;
    end else begin
      state   <= state_nx;
      ser_cnt <= (state == SERIAL) ? ~ser_cnt : 1'b0;
    end
  end
  // Per-register increment on issue and decrement on retire
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int i = 1; i < 32; i++) begin
      inc_vec[i] = issue && rd_w_ena && rd_w_addr == 5'(i);
      dec_vec[i] = wb_ok && wb_w_addr == 5'(i) && cnt[i] != 2'd0;
    end
  end
  // Scoreboard counters; entry 0 is never updated
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) cnt[i] <= 2'd0;
    end else begin
      for (int i = 1; i < 32; i++)
        cnt[i] <= (inc_vec[i] & ~dec_vec[i]) ? cnt[i] + 2'd1 :
                  (dec_vec[i] & ~inc_vec[i]) ? cnt[i] - 2'd1 : cnt[i];
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of scoreboard stalls, serialization, flush and reset
module tb_hazard_ctrl;
  logic clk, rst, id_valid, rs1_r_ena, rs2_r_ena, rd_w_ena, serialize, ex_redirect, wb_w_ena, mem_busy;
  logic [4:0] rs1_r_addr, rs2_r_addr, rd_w_addr, wb_w_addr;
  logic issue, if_stall, id_flush, ex_bubble, pipe_empty;
  int checks = 0;
  int errors = 0;
  hazard_ctrl #(.MAX_INFLIGHT(3)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .rs1_r_ena(rs1_r_ena), .rs1_r_addr(rs1_r_addr),
    .rs2_r_ena(rs2_r_ena), .rs2_r_addr(rs2_r_addr),
    .rd_w_ena(rd_w_ena), .rd_w_addr(rd_w_addr),
    .serialize(serialize), .ex_redirect(ex_redirect),
    .wb_w_ena(wb_w_ena), .wb_w_addr(wb_w_addr), .mem_busy(mem_busy),
    .issue(issue), .if_stall(if_stall), .id_flush(id_flush),
    .ex_bubble(ex_bubble), .pipe_empty(pipe_empty)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    id_valid = 0; rs1_r_ena = 0; rs1_r_addr = 0; rs2_r_ena = 0; rs2_r_addr = 0;
    rd_w_ena = 0; rd_w_addr = 0; serialize = 0; ex_redirect = 0;
    wb_w_ena = 0; wb_w_addr = 0; mem_busy = 0;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_issue"}, issue, 0);
    chk({tag, "_if_stall"}, if_stall, 0);
    chk({tag, "_id_flush"}, id_flush, 0);
    chk({tag, "_ex_bubble"}, ex_bubble, 0);
    chk({tag, "_pipe_empty"}, pipe_empty, 1);
  endtask
  initial begin
    idle;
    rst = 1; id_valid = 1; rd_w_ena = 1; rd_w_addr = 5; ex_redirect = 1;
    #1 chk_reset("rst");
    ex_redirect = 0;
    tick; tick;
    rst = 0;
    #1 chk("first_issue", issue, 1);
    chk("first_empty", pipe_empty, 1);
    tick;
    rd_w_ena = 0; rs1_r_ena = 1; rs1_r_addr = 5;
    #1 chk("raw_empty", pipe_empty, 0);
    chk("raw_issue", issue, 0);
    chk("raw_if_stall", if_stall, 1);
    chk("raw_bubble", ex_bubble, 1);
    tick;
    #1 chk("raw_issue2", issue, 0);
    wb_w_ena = 1; wb_w_addr = 5;
    #1 chk("raw_wb_issue", issue, 1);
    chk("raw_wb_stall", if_stall, 0);
    tick;
    idle;
    #1 chk("raw_done_empty", pipe_empty, 1);
    id_valid = 1; rd_w_ena = 1; rd_w_addr = 12; mem_busy = 1;
    #1 chk("busy_issue", issue, 0);
    chk("busy_stall", if_stall, 1);
    idle;
    id_valid = 1; rd_w_ena = 1; rd_w_addr = 0; rs1_r_ena = 1; rs1_r_addr = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("x0_issue", issue, 1);
      chk("x0_empty", pipe_empty, 1);
      tick;
    end
    #1 chk("x0_empty_end", pipe_empty, 1);
    idle;
    id_valid = 1; rd_w_ena = 1; rd_w_addr = 7;
    for (int i = 0; i < 3; i++) begin
      #1 chk("x7_issue", issue, 1);
      tick;
    end
    #1 chk("full_issue", issue, 0);
    chk("full_stall", if_stall, 1);
    tick;
    #1 chk("full_issue2", issue, 0);
    wb_w_ena = 1; wb_w_addr = 7;
    #1 chk("full_wb_issue", issue, 1);
    tick;
    id_valid = 0;
    tick; tick;
    #1 chk("x7_left", pipe_empty, 0);
    tick;
    idle;
    #1 chk("x7_empty", pipe_empty, 1);
    id_valid = 1; rd_w_ena = 1; rd_w_addr = 3;
    #1 chk("x3_issue", issue, 1);
    tick;
    serialize = 1; rd_w_addr = 10;
    #1 chk("csr_issue", issue, 0);
    chk("csr_stall", if_stall, 1);
    chk("csr_bubble", ex_bubble, 1);
    tick;
    #1 chk("drain_issue", issue, 0);
    chk("drain_stall", if_stall, 1);
    wb_w_ena = 1; wb_w_addr = 3;
    #1 chk("drain_wb_issue", issue, 0);
    tick;
    wb_w_ena = 0; wb_w_addr = 0;
    #1 chk("drain_empty", pipe_empty, 1);
    chk("drain_go_issue", issue, 1);
    chk("drain_go_stall", if_stall, 0);
    tick;
    serialize = 0; rd_w_addr = 11;
    #1 chk("ser1_issue", issue, 0);
    chk("ser1_stall", if_stall, 1);
    chk("ser1_bubble", ex_bubble, 1);
    tick;
    #1 chk("ser2_issue", issue, 0);
    chk("ser2_stall", if_stall, 1);
    tick;
    #1 chk("ser_run_issue", issue, 1);
    chk("ser_run_stall", if_stall, 0);
    id_valid = 0; wb_w_ena = 1; wb_w_addr = 10;
    tick;
    idle;
    #1 chk("ser_empty", pipe_empty, 1);
    id_valid = 1; rd_w_ena = 1; rd_w_addr = 4;
    tick;
    rd_w_ena = 0; rs1_r_ena = 1; rs1_r_addr = 4; ex_redirect = 1;
    #1 chk("redir_flush", id_flush, 1);
    chk("redir_issue", issue, 0);
    chk("redir_bubble", ex_bubble, 1);
    chk("redir_stall", if_stall, 0);
    tick;
    ex_redirect = 0;
    #1 chk("flush_issue", issue, 0);
    chk("flush_id_flush", id_flush, 0);
    chk("flush_bubble", ex_bubble, 1);
    tick;
    rs1_r_ena = 0; rs2_r_ena = 1; rs2_r_addr = 4;
    #1 chk("post_flush_issue", issue, 0);
    chk("post_flush_empty", pipe_empty, 0);
    chk("post_flush_stall", if_stall, 1);
    wb_w_ena = 1; wb_w_addr = 4;
    #1 chk("post_flush_wb_issue", issue, 1);
    tick;
    idle;
    #1 chk("x4_empty", pipe_empty, 1);
    id_valid = 1; rd_w_ena = 1; rd_w_addr = 9;
    tick;
    serialize = 1; rd_w_ena = 0;
    tick;
    #1 chk("rst_drain_stall", if_stall, 1);
    rst = 1;
    #1 chk_reset("rst_drain");
    tick;
    rst = 0;
    #1 chk("rst_rel_issue", issue, 1);
    idle;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
